// File: rtl/program_loader.sv
// ============================================================================
// program_loader: boot loader that assembles UART bytes into instruction words,
// writes them into instruction memory and holds the CPU in reset until a good load.
// Optional macro LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte.
// Revision: 1.0
// ============================================================================
`default_nettype none

module program_loader #(
  parameter int         ADDRESS_BITWIDTH = 10,
  parameter logic [7:0] ACK_OK           = 8'hAA,
  parameter logic [7:0] ACK_ERR          = 8'hEE
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  output logic [ADDRESS_BITWIDTH-1:0] imem_address,
  output logic [31:0]                 imem_write_data,
  output logic                        imem_wren,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        cpu_reset_n,
  output logic                        busy,
  output logic                        error
);

  localparam logic [32:0]               c_CAPACITY = 33'd1 << ADDRESS_BITWIDTH;
  localparam logic [ADDRESS_BITWIDTH:0] c_WORD_ONE = {{ADDRESS_BITWIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_HEADER,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_ACK,
    S_RUN,
    S_ERROR
  } state_t;

  state_t                      state_q, state_d;
  logic [1:0]                  byte_cnt_q, byte_cnt_d;
  logic [23:0]                 shift_q, shift_d;
  logic [ADDRESS_BITWIDTH:0]   n_q, n_d;
  logic [ADDRESS_BITWIDTH:0]   word_cnt_q, word_cnt_d;
  logic [ADDRESS_BITWIDTH-1:0] addr_q, addr_d;
  logic [31:0]                 wdata_q, wdata_d;
  logic                        wren_q, wren_d;
  logic [7:0]                  tx_data_q, tx_data_d;
  logic                        tx_valid_q, tx_valid_d;
  logic                        run_q, run_d;
  logic                        busy_q, busy_d;
  logic                        error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]                  sum_q, sum_d;
`endif

  logic [31:0]                 w_word;
  logic                        w_header_bad;
  logic                        w_handshake;
  logic [ADDRESS_BITWIDTH:0]   w_word_cnt_inc;

  // Bytes arrive LSB first, so the newest byte always lands in the top lane.
  assign w_word         = {rx_data, shift_q};
  assign w_header_bad   = (w_word == 32'd0) || ({1'b0, w_word} > c_CAPACITY);
  assign w_handshake    = tx_valid_q & tx_ready;
  assign w_word_cnt_inc = word_cnt_q + c_WORD_ONE;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wren_d     = 1'b0;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    run_d      = run_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif

    case (state_q)
      S_HEADER: begin
        if (rx_valid) begin
          shift_d    = w_word[31:8];
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Range check uses the full 32-bit count; only then is it truncated.
            n_d        = w_word[ADDRESS_BITWIDTH:0];
            word_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
            sum_d      = 8'd0;
`endif
            if (w_header_bad) begin
              state_d    = S_ERROR;
              tx_valid_d = 1'b1;
              tx_data_d  = ACK_ERR;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          shift_d    = w_word[31:8];
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_d      = sum_q + rx_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            wren_d     = 1'b1;
            addr_d     = word_cnt_q[ADDRESS_BITWIDTH-1:0];
            wdata_d    = w_word;
            word_cnt_d = w_word_cnt_inc;
            if (w_word_cnt_inc == n_q) begin
`ifdef LOADER_CHECKSUM_EN
              state_d    = S_CHECK;
`else
              state_d    = S_ACK;
              tx_valid_d = 1'b1;
              tx_data_d  = ACK_OK;
`endif
            end
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (rx_valid) begin
          tx_valid_d = 1'b1;
          if (rx_data == sum_q) begin
            state_d   = S_ACK;
            tx_data_d = ACK_OK;
          end else begin
            state_d   = S_ERROR;
            tx_data_d = ACK_ERR;
          end
        end
      end
`endif
      S_ACK: begin
        if (w_handshake) begin
          tx_valid_d = 1'b0;
          run_d      = 1'b1;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        run_d = 1'b1;
      end
      S_ERROR: begin
        if (w_handshake) begin
          tx_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_HEADER;
      end
    endcase

    busy_d = (state_d == S_HEADER) || (state_d == S_DATA)
`ifdef LOADER_CHECKSUM_EN
             || (state_d == S_CHECK)
`endif
             ;
    error_d = (state_d == S_ERROR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_HEADER;
      byte_cnt_q <= 2'd0;
      shift_q    <= 24'd0;
      n_q        <= '0;
      word_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      wren_q     <= 1'b0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      run_q      <= 1'b0;
      busy_q     <= 1'b1;
      error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      n_q        <= n_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wren_q     <= wren_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      run_q      <= run_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign imem_address    = addr_q;
  assign imem_write_data = wdata_q;
  assign imem_wren       = wren_q;
  assign tx_data         = tx_data_q;
  assign tx_valid        = tx_valid_q;
  assign cpu_reset_n     = run_q;
  assign busy            = busy_q;
  assign error           = error_q;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// tb_program_loader: directed self-checking bench; a stream-level model predicts
// every instruction-memory write and the CPU release cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_program_loader;

  localparam int c_AW  = 10;
  localparam int c_MAX = 32'h7fffffff;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [c_AW-1:0] imem_address;
  logic [31:0] imem_write_data;
  logic        imem_wren;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        cpu_reset_n;
  logic        busy;
  logic        error;

  program_loader #(.ADDRESS_BITWIDTH(c_AW), .ACK_OK(8'hAA), .ACK_ERR(8'hEE)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .imem_address(imem_address), .imem_write_data(imem_write_data), .imem_wren(imem_wren),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cpu_reset_n(cpu_reset_n), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] shadow[1024];
  int          cyc = 0;
  int          run_cyc = c_MAX;
  int          wr_count = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model: predicted writes and CPU release.
  always @(negedge clk) begin
    wr_t e;
    if (!reset) begin
      if (imem_wren) begin
        wr_count++;
        shadow[imem_address] = imem_write_data;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(imem_address), e.addr);
          check("wr_data", imem_write_data, e.data);
          check("wr_cycle", cyc, e.cyc);
        end
      end
      check("cpu_reset_n_model", 32'(cpu_reset_n), (cyc >= run_cyc) ? 32'd1 : 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic idle_rx();
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Drives a stream and predicts writes from the stream format alone.
  task automatic send_stream(input logic [7:0] s[$]);
    logic [31:0] n;
    logic [31:0] w;
    n = 32'd0;
    w = 32'd0;
    for (int i = 0; i < s.size(); i++) begin
      send_byte(s[i]);
      if (i < 4) begin
        n[8*i +: 8] = s[i];
      end else if (n != 32'd0 && n <= 32'd1024 && i < 4 + 4 * int'(n)) begin
        w[8*((i-4)%4) +: 8] = s[i];
        if ((i - 4) % 4 == 3) exp_q.push_back('{addr: (i - 4) / 4, data: w, cyc: cyc + 1});
      end
    end
  endtask

  function automatic logic [7:0] data_sum(input logic [7:0] s[$]);
    logic [7:0] acc;
    acc = 8'd0;
    for (int i = 4; i < s.size(); i++) acc = acc + s[i];
    return acc;
  endfunction

  task automatic finish_tx(input logic [7:0] exp_b, input int hold, input bit ok);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    tx_ready = (hold == 0);
    @(negedge clk);
    check("tx_valid_rise", 32'(tx_valid), 32'd1);
    check("tx_data", 32'(tx_data), 32'(exp_b));
    check("busy_done", 32'(busy), 32'd0);
    check("error_flag", 32'(error), ok ? 32'd0 : 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("tx_valid_hold", 32'(tx_valid), 32'd1);
      check("tx_data_hold", 32'(tx_data), 32'(exp_b));
      check("cpu_reset_n_hold", 32'(cpu_reset_n), 32'd0);
    end
    tx_ready = 1'b1;
    if (ok) run_cyc = cyc + 1;
    @(negedge clk);
    check("tx_valid_fall", 32'(tx_valid), 32'd0);
    check("cpu_reset_n_after", 32'(cpu_reset_n), ok ? 32'd1 : 32'd0);
    tx_ready = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    run_cyc  = c_MAX;
    reset    = 1'b1;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    #1;
    check("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    check("rst_imem_wren", 32'(imem_wren), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_error", 32'(error), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] s[$];
    int w0;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_imem_address", 32'(imem_address), 32'd0);
    check("reset_imem_write_data", imem_write_data, 32'd0);
    check("reset_imem_wren", 32'(imem_wren), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'd0);
    check("reset_tx_valid", 32'(tx_valid), 32'd0);
    check("reset_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    check("reset_busy", 32'(busy), 32'd1);
    check("reset_error", 32'(error), 32'd0);
    #2;
    reset = 1'b0;

    // Two-word load; tx_ready raised early has no effect before tx_valid.
    tx_ready = 1'b1;
    s = {8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'hB3, 8'h02, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    s.push_back(data_sum(s));
`endif
    w0 = wr_count;
    send_stream(s);
    finish_tx(8'hAA, 0, 1'b1);
    check("t1_write_count", wr_count - w0, 32'd2);
    check("t1_addr0_literal", shadow[0], 32'h00000513);
    check("t1_addr1_literal", shadow[1], 32'h000002B3);
    check("t1_drained", exp_q.size(), 32'd0);

    // Header N=0 and N=1025 are both rejected; later bytes are ignored.
    for (int t = 0; t < 2; t++) begin
      apply_reset();
      if (t == 0) s = {8'h00, 8'h00, 8'h00, 8'h00};
      else        s = {8'h01, 8'h04, 8'h00, 8'h00};
      w0 = wr_count;
      tx_ready = 1'b1;
      send_stream(s);
      finish_tx(8'hEE, 0, 1'b0);
      s = {8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      for (int i = 0; i < s.size(); i++) send_byte(s[i]);
      idle_rx();
      repeat (2) @(negedge clk);
      check("err_write_count", wr_count - w0, 32'd0);
      check("err_sticky", 32'(error), 32'd1);
      check("err_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
      check("err_tx_valid_low", 32'(tx_valid), 32'd0);
      check("err_busy", 32'(busy), 32'd0);
    end

    // Full-capacity load, one byte every cycle.
    apply_reset();
    s = {8'h00, 8'h04, 8'h00, 8'h00};
    for (int i = 0; i < 4096; i++) s.push_back(8'((i * 7 + 3) ^ (i >> 5)));
`ifdef LOADER_CHECKSUM_EN
    s.push_back(data_sum(s));
`endif
    w0 = wr_count;
    send_stream(s);
    finish_tx(8'hAA, 0, 1'b1);
    check("full_write_count", wr_count - w0, 32'd1024);
    check("full_drained", exp_q.size(), 32'd0);

    // Acknowledge held off by tx_ready for 10 cycles.
    apply_reset();
    s = {8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef LOADER_CHECKSUM_EN
    s.push_back(data_sum(s));
`endif
    send_stream(s);
    finish_tx(8'hAA, 10, 1'b1);
    check("hold_addr0_literal", shadow[0], 32'h44332211);

    // Reset from RUN, then reset mid-way through word 1, then a fresh load.
    apply_reset();
    s = {8'h02, 8'h00, 8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2};
    w0 = wr_count;
    send_stream(s);
    idle_rx();
    repeat (2) @(negedge clk);
    check("mid_write_count", wr_count - w0, 32'd1);
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_drained", exp_q.size(), 32'd0);
    apply_reset();
    s = {8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef LOADER_CHECKSUM_EN
    s.push_back(data_sum(s));
`endif
    send_stream(s);
    finish_tx(8'hAA, 0, 1'b1);
    check("fresh_addr0_literal", shadow[0], 32'h12345678);

`ifdef LOADER_CHECKSUM_EN
    apply_reset();
    s = {8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    send_stream(s);
    finish_tx(8'hAA, 0, 1'b1);
    apply_reset();
    s = {8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
    send_stream(s);
    finish_tx(8'hEE, 0, 1'b0);
    repeat (2) @(negedge clk);
    check("sum_bad_addr0", shadow[0], 32'h04030201);
    check("sum_bad_error", 32'(error), 32'd1);
    check("sum_bad_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
